// File: rtl/async_fifo_read_stream_adapter_if.sv
// ---------------------------------------------------------------------------
// async_fifo_read_stream_adapter_if
//
// Bundles the FIFO read port and the outgoing valid/ready stream used by
// async_fifo_read_stream_adapter.
//
//   fifo_empty : FIFO empty flag (read domain)
//   fifo_data  : FIFO head word, first-word-fall-through
//   fifo_pop   : pop the FIFO head on this clock edge
//   m_valid    : stream word valid
//   m_ready    : downstream accept
//   m_data     : stream word
//
// Modports:
//   master : the adapter (pops the FIFO, sources the stream)
//   slave  : the environment (FIFO model and stream sink)
// ---------------------------------------------------------------------------
interface async_fifo_read_stream_adapter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_pop;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_pop,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_pop,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/async_fifo_read_stream_adapter.sv
// ---------------------------------------------------------------------------
// async_fifo_read_stream_adapter
//
// Read-side consumer of an async FIFO. Pops words into a small prefetch
// buffer and re-presents them as a valid/ready stream. The pop decision uses
// only fifo_empty and registered occupancy, so m_ready never reaches fifo_pop
// combinationally. A level flush request drains and discards the FIFO and
// the buffer.
//
// Ports:
//   clk        : read-domain clock
//   reset      : synchronous, active-high reset
//   bus        : FIFO read port + output stream (master modport)
//   flush_req  : level request to drain and discard
//   flush_busy : high while flushing
//   buf_count  : prefetch buffer occupancy
//   word_count : saturating count of delivered words
// ---------------------------------------------------------------------------
module async_fifo_read_stream_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    async_fifo_read_stream_adapter_if.master bus,
    input  logic                         flush_req,
    output logic                         flush_busy,
    output logic [$clog2(BUF_DEPTH):0]   buf_count,
    output logic [CNT_WIDTH-1:0]         word_count
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic [CNT_WIDTH-1:0]  word_count_q;

    logic pop_w;
    logic m_valid_w;
    logic push;
    logic pop_out;
    logic flush_entry;

    // Pop whenever there is room (or always while flushing). Reset holds the
    // FIFO untouched.
    assign pop_w = !reset && !bus.fifo_empty &&
                   ((state_q == FLUSH) || (count_q < CW'(BUF_DEPTH)));

    assign m_valid_w   = (count_q != '0) && (state_q != FLUSH);
    assign push        = pop_w && (state_q != FLUSH);
    assign pop_out     = m_valid_w && bus.m_ready;
    assign count_d     = count_q + CW'(push) - CW'(pop_out);
    assign flush_entry = (state_d == FLUSH) && (state_q != FLUSH);

    assign bus.fifo_pop = pop_w;
    assign bus.m_valid  = m_valid_w;
    // Head slot is a register: no pass-through from fifo_data.
    assign bus.m_data   = mem_q[rd_ptr_q];
    assign flush_busy   = (state_q == FLUSH);
    assign buf_count    = count_q;
    assign word_count   = word_count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flush_req)
                    state_d = FLUSH;
                else if (!bus.fifo_empty)
                    state_d = STREAM;
            end
            STREAM: begin
                if (flush_req)
                    state_d = FLUSH;
                else if ((count_d == '0) && bus.fifo_empty)
                    state_d = IDLE;
            end
            FLUSH: begin
                if (!flush_req && bus.fifo_empty)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            // Entering or staying in FLUSH empties the buffer; a transfer on
            // the entry edge is still counted below.
            if (flush_entry || (state_q == FLUSH)) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push)
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop_out)
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_d;
            end
        end
    end

    // Prefetch storage; cleared on reset so the stream word starts at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++)
                mem_q[i] <= '0;
        end else if (push && !flush_entry) begin
            mem_q[wr_ptr_q] <= bus.fifo_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            word_count_q <= '0;
        else if (pop_out && (word_count_q != '1))
            word_count_q <= word_count_q + CNT_WIDTH'(1);
    end
endmodule

// File: doc/async_fifo_read_stream_adapter.md
Name: async_fifo_read_stream_adapter

Overview:
- Read-side consumer for the async FIFO. Runs in the read clock domain.
- Drives the FIFO pop/empty interface and re-presents the words as a registered valid/ready stream toward downstream logic.
- Holds a small prefetch buffer so the stream sustains 1 word/cycle under backpressure without combinational paths from m_ready to fifo_pop.
- Supports a flush command that drains and discards all FIFO and buffer contents.

Parameters:
- DATA_WIDTH, 32: width of FIFO data and stream data.
- BUF_DEPTH, 2: prefetch buffer entries; power of 2, at least 2.
- CNT_WIDTH, 16: width of the delivered-word statistics counter.

Ports:
- clk  input  1  read-domain clock.
- reset  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag, read domain.
- fifo_data  input  DATA_WIDTH  FIFO head word; valid while fifo_empty=0.
- fifo_pop  output  1  pops the FIFO head on this clk edge.
- m_valid  output  1  stream word valid.
- m_ready  input  1  downstream accept.
- m_data  output  DATA_WIDTH  stream word.
- flush_req  input  1  level request to drain and discard.
- flush_busy  output  1  high while in FLUSH.
- buf_count  output  $clog2(BUF_DEPTH)+1  prefetch buffer occupancy.
- word_count  output  CNT_WIDTH  saturating count of delivered words (m_valid && m_ready).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - fifo_pop=0, m_valid=0, m_data=0, flush_busy=0, buf_count=0, word_count=0.
  - Buffer read/write pointers = 0; state = IDLE.
  - Reset asserted mid-stream discards buffered words. FIFO contents are untouched.
- FIFO side:
  - fifo_data is first-word-fall-through: the head word is valid in the same cycle fifo_empty=0.
  - fifo_pop is combinational from fifo_empty and registered state only: fifo_pop = !fifo_empty && (state==FLUSH || buf_count < BUF_DEPTH). It never depends on m_ready.
  - When fifo_pop=1, fifo_data is written to the buffer tail at the clk edge (except in FLUSH, where it is discarded).
  - fifo_pop is never asserted while fifo_empty=1.
- Stream side:
  - m_valid = (buf_count != 0) && state != FLUSH.
  - m_data = buffer head entry, driven from a register/RAM slot with no fifo_data pass-through.
  - A transfer occurs when m_valid && m_ready; the head pointer advances at that edge.
  - m_data and m_valid stay stable while m_valid=1 and m_ready=0.
- Latency:
  - Word visible at FIFO in cycle N with the buffer empty → popped in N → m_valid=1 in N+1.
  - Steady-state throughput is 1 word/cycle with m_ready held high.
- Occupancy:
  - buf_count_next = buf_count + push - pop_out.
  - Simultaneous push and pop_out leaves buf_count unchanged.
  - Pointers are $clog2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH.
  - buf_count never exceeds BUF_DEPTH and never underflows.
- word_count increments on each transfer and saturates at 2^CNT_WIDTH-1. It is cleared only by reset; flush does not clear it.
- States:
  - IDLE: buf_count=0 and fifo_empty=1.
    - Go to STREAM when fifo_empty=0 and flush_req=0.
    - Go to FLUSH when flush_req=1.
  - STREAM: normal operation.
    - Go to IDLE when buf_count_next=0 and fifo_empty=1.
    - Go to FLUSH when flush_req=1; takes priority over all other transitions.
  - FLUSH:
    - flush_busy=1, m_valid=0.
    - Buffer cleared on the entry edge: pointers=0, buf_count=0.
    - Pops on every cycle with fifo_empty=0 and discards the data.
    - Go to IDLE when flush_req=0 and fifo_empty=1 in the same cycle.
- Simultaneous events:
  - flush_req rising in the same cycle as a transfer: the transfer completes and counts, then the buffer is cleared.
  - Words arriving during FLUSH are discarded for as long as flush_req stays high.

Test Plan:
- Reset, then FIFO presents 0xA5A5_0001 with m_ready=1 → fifo_pop high that cycle; next cycle m_valid=1, m_data=0xA5A5_0001; word_count=1 after the handshake.
- 8 words 1..8 queued, m_ready=1 throughout → 8 consecutive cycles with m_valid=1 and data 1..8 in order; fifo_pop high for 8 consecutive cycles; final word_count=8, buf_count=0.
- 5 words queued, m_ready=0 → exactly 2 pops, buf_count=2, m_data=1 held stable. Release m_ready → words 1..5 delivered in order with no loss or duplication.
- Random m_ready toggling over 200 words with a random empty pattern → scoreboard shows in-order data; fifo_pop never asserted with fifo_empty=1; buf_count ≤ 2.
- Hold m_ready=0 with buf_count=2, then assert flush_req for 6 cycles while 4 more words arrive → m_valid=0 and flush_busy=1 from the next cycle; 4 pops discarded; return to IDLE with buf_count=0; word_count unchanged.
- Assert reset for 1 cycle with buf_count=2 mid-stream → next cycle m_valid=0, buf_count=0, word_count=0, fifo_pop=0 during the reset cycle.
